checkout_controller: RTL and testbench

- Sequencer for the UPC discount/stolen checkout logic on the DE1-SoC lab board.
- Captures one item per scan: a rising edge of the scan input latches the UPC digits and the secret mark.
- Classifies the captured item, then updates running tallies for the board readout.
- Holds a stolen-item alarm for a minimum time and releases it only after operator acknowledge.

---
 rtl/checkout_pkg.sv | 20 ++
 rtl/upc_classify.sv | 28 ++
 rtl/checkout_controller.sv | 147 ++++++++++++++
 tb/tb_checkout_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/checkout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : checkout_pkg
// Description : Shared state encoding and UPC digit positions for checkout.
// Revision    : 1.0 - initial release
// ============================================================================
package checkout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam int UPC_U = 2;
    localparam int UPC_P = 1;
    localparam int UPC_C = 0;

endpackage
`default_nettype wire

// File: rtl/upc_classify.sv
`default_nettype none
// ============================================================================
// Module      : upc_classify
// Description : Combinational discount / stolen classification of one item.
// Revision    : 1.0 - initial release
// ============================================================================
module upc_classify
    import checkout_pkg::*;
(
    input  logic [2:0] upc,
    input  logic       mark,
    output logic       discounted,
    output logic       stolen
);

    logic w_u;
    logic w_p;
    logic w_c;

    assign w_u = upc[UPC_U];
    assign w_p = upc[UPC_P];
    assign w_c = upc[UPC_C];

    assign discounted = w_p | (w_u & w_c);
    assign stolen     = ~mark & ((~w_p & ~w_c) | (w_u & ~w_p));

endmodule
`default_nettype wire

// File: rtl/checkout_controller.sv
`default_nettype none
// ============================================================================
// Module      : checkout_controller
// Description : Scan capture, classification sequencing, tallies and alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module checkout_controller
    import checkout_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int ALARM_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scan,
    input  logic [2:0]       upc,
    input  logic             mark,
    input  logic             ack_alarm,
    input  logic             clear,
    output logic             busy,
    output logic             discounted,
    output logic             stolen,
    output logic             alarm,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] discount_count,
    output logic [CNT_W-1:0] stolen_count
);

    localparam logic [7:0] c_timer_load = 8'(ALARM_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_scan_q;
    logic [2:0]       r_upc;
    logic             r_mark;
    logic [7:0]       r_timer;
    logic             r_discounted;
    logic             r_stolen;
    logic [CNT_W-1:0] r_item_count;
    logic [CNT_W-1:0] r_discount_count;
    logic [CNT_W-1:0] r_stolen_count;
    logic             w_scan_rise;
    logic             w_discounted;
    logic             w_stolen;

    assign w_scan_rise = scan & ~r_scan_q;

    upc_classify u_classify (
        .upc        (r_upc),
        .mark       (r_mark),
        .discounted (w_discounted),
        .stolen     (w_stolen)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_scan_rise) w_state_next = EVAL;
                EVAL:    w_state_next = w_stolen ? ALARM : IDLE;
                ALARM:   if ((r_timer == 8'd0) && ack_alarm) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // The alarm is exactly the ALARM state: it is entered and left on the same edges.
    always_comb begin
        busy  = (r_state != IDLE);
        alarm = (r_state == ALARM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_q         <= 1'b0;
            r_upc            <= 3'b000;
            r_mark           <= 1'b0;
            r_timer          <= 8'd0;
            r_discounted     <= 1'b0;
            r_stolen         <= 1'b0;
            r_item_count     <= '0;
            r_discount_count <= '0;
            r_stolen_count   <= '0;
        end else begin
            r_scan_q <= scan;
            if (clear) begin
                r_timer          <= 8'd0;
                r_discounted     <= 1'b0;
                r_stolen         <= 1'b0;
                r_item_count     <= '0;
                r_discount_count <= '0;
                r_stolen_count   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_scan_rise) begin
                            r_upc  <= upc;
                            r_mark <= mark;
                        end
                    end
                    EVAL: begin
                        r_discounted     <= w_discounted;
                        r_stolen         <= w_stolen;
                        r_item_count     <= sat_inc(r_item_count, 1'b1);
                        r_discount_count <= sat_inc(r_discount_count, w_discounted);
                        r_stolen_count   <= sat_inc(r_stolen_count, w_stolen);
                        if (w_stolen) begin
                            r_timer <= c_timer_load;
                        end
                    end
                    ALARM: begin
                        if (r_timer != 8'd0) begin
                            r_timer <= r_timer - 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign discounted     = r_discounted;
    assign stolen         = r_stolen;
    assign item_count     = r_item_count;
    assign discount_count = r_discount_count;
    assign stolen_count   = r_stolen_count;

endmodule
`default_nettype wire

// File: tb/tb_checkout_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_checkout_controller
// Description : Directed self-checking bench for checkout_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_checkout_controller;

    logic       clk;
    logic       reset_n;
    logic       scan;
    logic [2:0] upc;
    logic       mark;
    logic       ack_alarm;
    logic       clear;
    logic       busy;
    logic       discounted;
    logic       stolen;
    logic       alarm;
    logic [3:0] item_count;
    logic [3:0] discount_count;
    logic [3:0] stolen_count;

    int n_checks = 0;
    int n_pass   = 0;

    checkout_controller #(
        .CNT_W        (4),
        .ALARM_CYCLES (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .scan           (scan),
        .upc            (upc),
        .mark           (mark),
        .ack_alarm      (ack_alarm),
        .clear          (clear),
        .busy           (busy),
        .discounted     (discounted),
        .stolen         (stolen),
        .alarm          (alarm),
        .item_count     (item_count),
        .discount_count (discount_count),
        .stolen_count   (stolen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One scan: rise captured at the next edge, EVAL completes on the edge after.
    task automatic scan_item(input logic [2:0] u, input logic m);
        upc  = u;
        mark = m;
        scan = 1'b1;
        @(negedge clk);
        check("eval_busy", {31'd0, busy}, 32'd1);
        scan = 1'b0;
        @(negedge clk);
    endtask

    task automatic alarm_length(output int n);
        n = 0;
        while (alarm === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n   = 1'b0;
        scan      = 1'b0;
        upc       = 3'b000;
        mark      = 1'b0;
        ack_alarm = 1'b0;
        clear     = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_busy",   {31'd0, busy},       32'd0);
        check("rst_disc",   {31'd0, discounted}, 32'd0);
        check("rst_stolen", {31'd0, stolen},     32'd0);
        check("rst_alarm",  {31'd0, alarm},      32'd0);
        check("rst_items",  {28'd0, item_count}, 32'd0);
        check("rst_dcnt",   {28'd0, discount_count}, 32'd0);
        check("rst_scnt",   {28'd0, stolen_count},   32'd0);

        // Discounted item
        scan_item(3'b010, 1'b0);
        check("d_busy",   {31'd0, busy},       32'd0);
        check("d_disc",   {31'd0, discounted}, 32'd1);
        check("d_stolen", {31'd0, stolen},     32'd0);
        check("d_alarm",  {31'd0, alarm},      32'd0);
        check("d_items",  {28'd0, item_count}, 32'd1);
        check("d_dcnt",   {28'd0, discount_count}, 32'd1);

        // Stolen item with ack already high: alarm lasts exactly 8 cycles
        ack_alarm = 1'b1;
        scan_item(3'b000, 1'b0);
        check("s_stolen", {31'd0, stolen},       32'd1);
        check("s_disc",   {31'd0, discounted},   32'd0);
        check("s_alarm",  {31'd0, alarm},        32'd1);
        check("s_scnt",   {28'd0, stolen_count}, 32'd1);
        check("s_items",  {28'd0, item_count},   32'd2);
        alarm_length(n);
        check("s_alarm_len", n, 32'd8);
        check("s_busy_after", {31'd0, busy}, 32'd0);
        ack_alarm = 1'b0;

        // Stolen item, no ack: alarm persists; scans during ALARM are dropped
        scan_item(3'b000, 1'b0);
        repeat (30) @(negedge clk);
        check("hold_alarm", {31'd0, alarm}, 32'd1);
        repeat (3) begin
            scan = 1'b1;
            @(negedge clk);
            scan = 1'b0;
            @(negedge clk);
        end
        scan = 1'b1;
        @(negedge clk);
        ack_alarm = 1'b1;
        @(negedge clk);
        check("ack_alarm_off", {31'd0, alarm}, 32'd0);
        ack_alarm = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_items", {28'd0, item_count}, 32'd3);
        check("drop_busy",  {31'd0, busy},       32'd0);
        scan = 1'b0;
        @(negedge clk);

        // Marked item: neither flag
        scan_item(3'b100, 1'b1);
        check("m_disc",   {31'd0, discounted}, 32'd0);
        check("m_stolen", {31'd0, stolen},     32'd0);
        check("m_alarm",  {31'd0, alarm},      32'd0);
        check("m_items",  {28'd0, item_count}, 32'd4);

        // Dual-flag item
        ack_alarm = 1'b1;
        scan_item(3'b101, 1'b0);
        check("x_disc",   {31'd0, discounted},     32'd1);
        check("x_stolen", {31'd0, stolen},         32'd1);
        check("x_dcnt",   {28'd0, discount_count}, 32'd2);
        check("x_scnt",   {28'd0, stolen_count},   32'd3);
        check("x_items",  {28'd0, item_count},     32'd5);
        alarm_length(n);
        check("x_alarm_len", n, 32'd8);
        ack_alarm = 1'b0;

        // Clear, then saturation
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_items", {28'd0, item_count},   32'd0);
        check("clr_scnt",  {28'd0, stolen_count}, 32'd0);
        check("clr_disc",  {31'd0, discounted},   32'd0);
        check("clr_stol",  {31'd0, stolen},       32'd0);
        for (int i = 0; i < 17; i++) begin
            scan_item(3'b010, 1'b0);
            if (i == 9) check("sat_items10", {28'd0, item_count}, 32'd10);
        end
        check("sat_items", {28'd0, item_count},     32'd15);
        check("sat_dcnt",  {28'd0, discount_count}, 32'd15);
        check("sat_scnt",  {28'd0, stolen_count},   32'd0);
        check("sat_disc",  {31'd0, discounted},     32'd1);

        // Clear coincident with scan rise: scan not counted
        upc   = 3'b010;
        mark  = 1'b0;
        scan  = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("cs_busy",  {31'd0, busy},           32'd0);
        check("cs_items", {28'd0, item_count},     32'd0);
        check("cs_dcnt",  {28'd0, discount_count}, 32'd0);
        check("cs_disc",  {31'd0, discounted},     32'd0);
        @(negedge clk);
        check("cs_held_busy", {31'd0, busy}, 32'd0);
        scan = 1'b0;
        @(negedge clk);
        scan_item(3'b010, 1'b0);
        check("cs_next_items", {28'd0, item_count}, 32'd1);

        // Asynchronous reset in the middle of ALARM
        scan_item(3'b000, 1'b0);
        check("ar_alarm_on", {31'd0, alarm}, 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("ar_alarm", {31'd0, alarm},        32'd0);
        check("ar_busy",  {31'd0, busy},         32'd0);
        check("ar_items", {28'd0, item_count},   32'd0);
        check("ar_scnt",  {28'd0, stolen_count}, 32'd0);
        check("ar_stol",  {31'd0, stolen},       32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ar_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
